// File: rtl/soc_io_pkg.sv
// soc_io_pkg: shared types and constants for board input conditioning
// Holds the per-channel debounce FSM state encoding.
// Holds the default debounce length (10 ms at 100 MHz).
package soc_io_pkg;
  typedef enum logic {STABLE, PENDING} db_state_t;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise, debounce and edge-detect one raw input
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   raw        : asynchronous bouncy input
//   level      : debounced level
//   rise, fall : one-cycle pulses aligned with the first cycle of a new level
module debounce_channel
  import soc_io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, sync;
  logic [CW-1:0] cnt;
  db_state_t state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= RESET_LEVEL;
      sync  <= RESET_LEVEL;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
      state <= STABLE;
    end else begin
      s1   <= raw;
      sync <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (state == STABLE) begin
        cnt <= '0;
        if (sync != level) begin
          state <= PENDING;
          cnt   <= CW'(1);
        end
      end else if (sync == level) begin
        state <= STABLE;
        cnt   <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
        rise  <= sync;
        fall  <= ~sync;
        state <= STABLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: WIDTH independent debounced board inputs with edge pulses
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   raw        : asynchronous bouncy inputs
//   level      : debounced levels
//   rise, fall : per-channel one-cycle transition pulses
module input_conditioner
  import soc_io_pkg::*;
#(
  parameter int               WIDTH           = 3,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed vector bench for input_conditioner
module tb_input_conditioner;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] raw, level, rise, fall;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic [2:0] raw;
    logic [2:0] level;
    logic [2:0] rise;
    logic [2:0] fall;
  } vec_t;
  vec_t vq[$];

  input_conditioner #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(3'b000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [2:0] rw, lv, ri, fa, input int n);
    vec_t v;
    v.rst_n = r; v.raw = rw; v.level = lv; v.rise = ri; v.fall = fa;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [2:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    int falls;
    rst_n = 1'b0;
    raw   = 3'b111;
    // reset with raw high, then release: new transition on all channels
    add(0, 3'b111, 3'b000, 3'b000, 3'b000, 3);
    add(1, 3'b111, 3'b000, 3'b000, 3'b000, 5);
    add(1, 3'b111, 3'b111, 3'b111, 3'b000, 1);
    add(1, 3'b111, 3'b111, 3'b000, 3'b000, 1);
    // all channels released together
    add(1, 3'b000, 3'b111, 3'b000, 3'b000, 5);
    add(1, 3'b000, 3'b000, 3'b000, 3'b111, 1);
    add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    // clean press on channel 0
    add(1, 3'b001, 3'b000, 3'b000, 3'b000, 5);
    add(1, 3'b001, 3'b001, 3'b001, 3'b000, 1);
    add(1, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    // 3-cycle glitch on channel 1 is rejected
    add(1, 3'b011, 3'b001, 3'b000, 3'b000, 3);
    add(1, 3'b001, 3'b001, 3'b000, 3'b000, 5);
    // 4-cycle pulse on channel 1 just qualifies, then its release
    add(1, 3'b011, 3'b001, 3'b000, 3'b000, 4);
    add(1, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    add(1, 3'b001, 3'b011, 3'b010, 3'b000, 1);
    add(1, 3'b001, 3'b011, 3'b000, 3'b000, 3);
    add(1, 3'b001, 3'b001, 3'b000, 3'b010, 1);
    add(1, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    // bouncing press on channel 2
    add(1, 3'b101, 3'b001, 3'b000, 3'b000, 1);
    add(1, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    add(1, 3'b101, 3'b001, 3'b000, 3'b000, 1);
    add(1, 3'b001, 3'b001, 3'b000, 3'b000, 1);
    add(1, 3'b101, 3'b001, 3'b000, 3'b000, 5);
    add(1, 3'b101, 3'b101, 3'b100, 3'b000, 1);
    add(1, 3'b101, 3'b101, 3'b000, 3'b000, 1);
    // channel 0 release interrupted by reset mid-count
    add(1, 3'b100, 3'b101, 3'b000, 3'b000, 4);
    add(0, 3'b100, 3'b000, 3'b000, 3'b000, 1);
    add(1, 3'b100, 3'b000, 3'b000, 3'b000, 5);
    add(1, 3'b100, 3'b100, 3'b100, 3'b000, 1);
    add(1, 3'b100, 3'b100, 3'b000, 3'b000, 1);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      raw   = vq[i].raw;
      @(posedge clk);
      #1;
      chk("level", i, level, vq[i].level);
      chk("rise",  i, rise,  vq[i].rise);
      chk("fall",  i, fall,  vq[i].fall);
    end

    // press channel 1 and time the rise pulse with a bounded wait
    raw   = 3'b110;
    n     = 0;
    falls = 0;
    while (n < 20 && !rise[1]) begin
      @(posedge clk);
      #1;
      n++;
      if ((rise & fall) != 3'b000 || fall != 3'b000) falls++;
    end
    chk("rise_latency", n, 3'(n), 3'd6);
    chk("press_level", n, level, 3'b110);
    chk("press_rise", n, rise, 3'b010);
    chk("no_stray_fall", n, 3'(falls), 3'd0);
    @(posedge clk);
    #1;
    chk("press_rise_clear", n + 1, rise, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
